// File: rtl/wbc_rr_intercon.sv
// rtl/wbc_rr_intercon.sv - WISHBONE classic NM x NS shared-bus round-robin interconnect
//
// Purpose:
//   Shares one WISHBONE classic bus between NM masters and NS slaves.
//   - A registered round-robin arbiter holds the grant for a whole cycle.
//   - A base/mask decoder selects a slave. The lowest index wins on overlap.
//   - Strobes to an unmapped address get an interconnect error response.
//   - WBC_TIMEOUT_EN (optional) adds a watchdog. It errors out and aborts
//     a stalled slave cycle after TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i                 clock and asynchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i       per-master controls (NM bits each)
//   m_adr_i/m_dat_i/m_sel_i      per-master address, write data, byte selects
//   m_ack_o/m_err_o/m_rty_o      per-master terminations, owner only
//   m_dat_o                      shared read data (0 when no slave selected)
//   gnt_o                        one-hot current grant
//   s_cyc_o/s_stb_o/s_we_o       per-slave controls (NS bits each)
//   s_adr_o                      per-slave address, already masked to its offset
//   s_dat_o/s_sel_o              shared write data and byte selects
//   s_ack_i/s_err_i/s_rty_i      per-slave terminations
//   s_dat_i                      per-slave read data
module wbc_rr_intercon #(
  parameter int NM = 3,
  parameter int NS = 4,
  parameter int DW = 32,
  parameter int AW = 20,
  parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK = '1,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic [NM-1:0]      m_rty_o,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      gnt_o,
  output logic [NS-1:0]      s_cyc_o,
  output logic [NS-1:0]      s_stb_o,
  output logic [NS-1:0]      s_we_o,
  output logic [NS*AW-1:0]   s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  input  logic [NS-1:0]      s_ack_i,
  input  logic [NS-1:0]      s_err_i,
  input  logic [NS-1:0]      s_rty_i,
  input  logic [NS*DW-1:0]   s_dat_i
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t         r_state;
  logic [NM-1:0]  r_gnt;
  logic [IW-1:0]  r_gnt_idx;
  logic [IW-1:0]  r_ptr;
  logic           r_derr;

  logic           w_found;
  logic [IW-1:0]  w_nxt_idx;
  logic           w_own_cyc, w_own_stb, w_own_we;
  logic [AW-1:0]  w_own_adr;
  logic [DW-1:0]  w_own_dat;
  logic [SW-1:0]  w_own_sel;
  logic [NS-1:0]  w_dec, w_hit;
  logic           w_dec_found, w_hit_any;
  logic           w_s_ack, w_s_err, w_s_rty, w_term;
  logic [DW-1:0]  w_rdat;
  logic           w_abort, w_terr;

  // Round-robin search: first requester above ptr, then wrap to 0..ptr.
  always_comb begin
    w_found   = 1'b0;
    w_nxt_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (!w_found && m_cyc_i[i] && (i > int'(r_ptr))) begin
        w_found   = 1'b1;
        w_nxt_idx = IW'(i);
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!w_found && m_cyc_i[i] && (i <= int'(r_ptr))) begin
        w_found   = 1'b1;
        w_nxt_idx = IW'(i);
      end
    end
  end

  // Owner mux. The grant is one-hot, so AND-OR selection suffices.
  assign w_own_cyc = |(m_cyc_i & r_gnt);
  assign w_own_stb = |(m_stb_i & m_cyc_i & r_gnt);
  assign w_own_we  = |(m_we_i & r_gnt);

  always_comb begin
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    for (int i = 0; i < NM; i++) begin
      w_own_adr = w_own_adr | (m_adr_i[i*AW +: AW] & {AW{r_gnt[i]}});
      w_own_dat = w_own_dat | (m_dat_i[i*DW +: DW] & {DW{r_gnt[i]}});
      w_own_sel = w_own_sel | (m_sel_i[i*SW +: SW] & {SW{r_gnt[i]}});
    end
  end

  // Address decode with lowest-index priority.
  always_comb begin
    w_dec       = '0;
    w_dec_found = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (!w_dec_found &&
          ((w_own_adr & ~SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW])) begin
        w_dec_found = 1'b1;
        w_dec[k]    = 1'b1;
      end
    end
  end

  assign w_hit     = w_dec & {NS{w_own_cyc}};
  assign w_hit_any = |w_hit;

  assign w_s_ack = |(s_ack_i & w_hit);
  assign w_s_err = |(s_err_i & w_hit);
  assign w_s_rty = |(s_rty_i & w_hit);
  assign w_term  = w_s_ack | w_s_err | w_s_rty;

  always_comb begin
    w_rdat = '0;
    for (int k = 0; k < NS; k++) begin
      w_rdat = w_rdat | (s_dat_i[k*DW +: DW] & {DW{w_hit[k]}});
    end
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      s_adr_o[k*AW +: AW] = w_own_adr & SLAVE_MASK[k*AW +: AW];
    end
  end

  assign s_cyc_o = w_hit & {NS{~w_abort}};
  assign s_stb_o = s_cyc_o & {NS{w_own_stb}};
  assign s_we_o  = s_cyc_o & {NS{w_own_we}};
  assign s_dat_o = w_own_dat;
  assign s_sel_o = w_own_sel;

  assign m_dat_o = w_rdat;
  assign gnt_o   = r_gnt;
  assign m_ack_o = r_gnt & {NM{w_s_ack & ~w_abort}};
  assign m_rty_o = r_gnt & {NM{w_s_rty & ~w_abort}};
  assign m_err_o = r_gnt & {NM{w_own_cyc & ((w_s_err & ~w_abort) | r_derr | w_terr)}};

  // Arbiter FSM and unmapped-address error. The self-clearing r_derr
  // guarantees a low cycle between repeated error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= IW'(NM - 1);
      r_derr    <= 1'b0;
    end else begin
      r_derr <= w_own_stb & ~w_hit_any & ~r_derr;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt     <= NM'(1) << w_nxt_idx;
            r_gnt_idx <= w_nxt_idx;
            r_state   <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!w_own_cyc) begin
            r_gnt   <= '0;
            r_ptr   <= r_gnt_idx;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WBC_TIMEOUT_EN
  localparam logic [15:0] LP_TO = 16'(TIMEOUT);

  logic [15:0] r_wdt;
  logic        r_abort;
  logic        r_terr;

  // The abort flag masks the slave until the owner drops stb. This keeps a
  // late ack from the stalled slave from reaching the master.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdt   <= '0;
      r_abort <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_terr <= 1'b0;
      if (!w_own_stb) begin
        r_wdt   <= '0;
        r_abort <= 1'b0;
      end else if (r_abort || w_term || !w_hit_any) begin
        r_wdt <= '0;
      end else if (r_wdt == (LP_TO - 16'd1)) begin
        r_wdt   <= '0;
        r_terr  <= 1'b1;
        r_abort <= 1'b1;
      end else begin
        r_wdt <= r_wdt + 16'd1;
      end
    end
  end

  assign w_abort = r_abort;
  assign w_terr  = r_terr;
`else
  logic w_unused_wdt;
  assign w_abort      = 1'b0;
  assign w_terr       = 1'b0;
  assign w_unused_wdt = w_term ^ (TIMEOUT > 0);
`endif

endmodule

// File: doc/wbc_rr_intercon.md
# wbc_rr_intercon

Parametrised WISHBONE classic shared-bus interconnect connecting NM masters to NS slaves, the generalised successor of the fixed SURF control-bus intercon. It provides:
- a registered round-robin arbiter that holds the grant for a whole cycle;
- a per-slave base/mask address decoder;
- an interconnect-generated error response for unmapped addresses;
- an optional watchdog that terminates stalled slave cycles.

It sits between the PCI/TURF/housekeeping control masters and the register-space slaves.

## Interface
Parameters:
- NM, 3, number of masters (1..8)
- NS, 4, number of slaves (1..16)
- DW, 32, data width (multiple of 8)
- AW, 20, address width
- SLAVE_BASE, {NS{AW'h0}}, flattened per-slave base; slave k in bits [k*AW +: AW]
- SLAVE_MASK, {NS{AW'hFFFFF}}, flattened per-slave offset mask (1 = offset bit)
- TIMEOUT, 255, watchdog limit in cycles (1..65535)

Ports:
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- m_cyc_i, m_stb_i, m_we_i  in  NM each  per-master controls
- m_adr_i  in  NM*AW  per-master address
- m_dat_i  in  NM*DW  per-master write data
- m_sel_i  in  NM*DW/8  per-master byte selects
- m_ack_o, m_err_o, m_rty_o  out  NM each  per-master terminations
- m_dat_o  out  DW  shared read data
- gnt_o  out  NM  one-hot current grant (status)
- s_cyc_o, s_stb_o, s_we_o  out  NS each  per-slave controls
- s_adr_o  out  NS*AW  per-slave address, pre-masked (adr & mask)
- s_dat_o  out  DW  shared write data
- s_sel_o  out  DW/8  shared byte selects
- s_ack_i, s_err_i, s_rty_i  in  NS each  per-slave terminations
- s_dat_i  in  NS*DW  per-slave read data

## Operation
- States: IDLE, OWN.
- IDLE: if any m_cyc_i is high, register a grant to the first requester at or after ptr+1 (mod NM), then go to OWN.
- OWN: hold the grant while the granted master's cyc is high. When it drops, clear the grant, set ptr = granted index, and go to IDLE.
- Other masters' cyc/stb are ignored while another master owns the bus.
- Decode: sel_k = ((adr & ~MASK_k) == BASE_k). The lowest k wins on overlap.
- s_cyc_o[k] = owner cyc & sel_k. s_stb_o[k] and s_we_o[k] are similarly gated. The shared s_dat_o/s_sel_o come from the owner.
- Read data and ack/err/rty are muxed from the selected slave and routed only to the owner. All other masters see 0.
- No slave matches while the owner has stb high:
  - no s_cyc_o is asserted;
  - the interconnect registers m_err_o high for exactly one cycle, followed by at least one low cycle;
  - if stb is still high after that, the same sequence repeats.
- Simultaneous release and request: cyc drop and a new request in the same cycle give one IDLE cycle, then a grant to the next requester by round-robin.

## Timing
- Reset values:
  - gnt_o = 0, ptr = NM-1, so master 0 wins first;
  - all s_cyc_o/s_stb_o/s_we_o = 0;
  - all m_ack_o/m_err_o/m_rty_o = 0;
  - m_dat_o = 0 when no slave is selected;
  - watchdog count = 0.
- Grant latency: cyc rises at edge n, grant at edge n+1, slave cyc visible in cycle n+1.
- Slave-to-master ack/err/rty/data path: combinational, zero added latency.
- Decode error: err asserted one cycle after stb is sampled with no match.
- Asynchronous reset mid-cycle: all slave strobes and the grant drop immediately, with no termination issued.
- Back-to-back: a master re-requesting after release loses to any other pending requester.

## Configuration
WBC_TIMEOUT_EN defined:
- A 16-bit counter increments while the owner's stb is high and the selected slave gives no ack/err/rty.
- It clears on any termination, or when stb is low.
- On reaching TIMEOUT, m_err_o pulses for one cycle.
- The slave's s_stb_o/s_cyc_o are then masked (abort flag) until the owner drops stb.

WBC_TIMEOUT_EN undefined:
- No counter exists; a stalled slave holds the bus indefinitely.

## Test plan
- Reset, then master 0 single write to 0x10004 (slave 1 base 0x10000, mask 0x0FFFF) -> s_cyc_o[1]=1, s_adr_o slave1=0x00004, m_ack_o[0] same cycle as s_ack_i[1].
- Masters 0,1,2 assert cyc together, each holding 3 cycles -> grants 0,1,2 in order with one IDLE cycle between; repeat -> order 0,1,2 again.
- Master 1 owns the bus while master 2 requests; master 1 drops cyc and re-requests the same cycle -> master 2 granted next.
- Read of unmapped 0xF0000 with no slave matching -> no s_cyc_o, m_err_o pulses 1 cycle, 1 cycle after stb.
- With WBC_TIMEOUT_EN and TIMEOUT=16, slave never acks -> m_err_o at cycle 16 of stb, s_stb_o low until master drops stb.
- Assert rst_i mid-transfer -> s_cyc_o and gnt_o = 0 before the next edge; next request goes to master 0.
